// File: rtl/dbus_arbiter.sv
// dbus_arbiter: merges N bus masters onto one data-bus channel.
// One transaction in flight; round-robin or aged fixed-priority grant.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int NPORT = 3,
  parameter int MODE = 0,
  parameter int AGE_LIMIT = 4,
  localparam int OW = $clog2(NPORT),
  localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  dbus_req_t     req  [NPORT],
  output dbus_resp_t    resp [NPORT],
  output dbus_req_t     mreq,
  input  dbus_resp_t    mresp,
  output logic          busy,
  output logic [OW-1:0] owner
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  dbus_req_t     lreq;
  logic [OW-1:0] rr_ptr;
  logic [AW-1:0] age [NPORT];

  logic [OW-1:0] sel, sel_rr, sel_lo, sel_age, route, route_nxt;
  logic          any_valid, aged_hit, grant, done;
  int            idx;

  always_comb begin
    any_valid = 1'b0;
    aged_hit  = 1'b0;
    sel_rr    = '0;
    sel_lo    = '0;
    sel_age   = '0;
    idx       = 0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(rr_ptr) + k) % NPORT;
      if (!any_valid && req[idx].valid) begin
        any_valid = 1'b1;
        sel_rr    = OW'(idx);
      end
    end
    // Descending scan so the lowest index is the last one written.
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (req[i].valid) begin
        sel_lo = OW'(i);
        if (AGE_LIMIT > 0 && age[i] == AW'(AGE_LIMIT)) begin
          sel_age  = OW'(i);
          aged_hit = 1'b1;
        end
      end
    end
    sel = (MODE == 1) ? (aged_hit ? sel_age : sel_lo) : sel_rr;
  end

  always_comb begin
    state_n = state;
    grant   = (state == IDLE) && any_valid;
    route   = (state == BUSY) ? owner : sel;
    done    = mresp.data_ok && ((state == BUSY) || grant);
    mreq    = '0;
    busy    = 1'b0;
    for (int i = 0; i < NPORT; i++) resp[i] = '0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          mreq = req[sel];
          if (!mresp.data_ok) state_n = BUSY;
        end
      end
      BUSY: begin
        mreq       = lreq;
        mreq.valid = 1'b1;
        busy       = 1'b1;
        if (mresp.data_ok) state_n = IDLE;
      end
    endcase
    if ((state == BUSY) || grant) resp[route] = mresp;
    if (reset) begin
      mreq = '0;
      busy = 1'b0;
      for (int i = 0; i < NPORT; i++) resp[i] = '0;
    end
  end

  assign route_nxt = (route == OW'(NPORT - 1)) ? '0 : route + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      lreq   <= '0;
      for (int i = 0; i < NPORT; i++) age[i] <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner <= sel;
        lreq  <= req[sel];
      end
      if (done) rr_ptr <= route_nxt;
      for (int i = 0; i < NPORT; i++) begin
        if (done && OW'(i) == route)
          age[i] <= '0;
        else if (MODE == 1 && grant && req[i].valid &&
                 OW'(i) != sel && age[i] != AW'(AGE_LIMIT))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule
